// File: rtl/key_freq_set_if.sv
// Front-panel key / frequency-word bundle between the button stage and its consumers.
// master drives the raw keys and observes the outputs; slave is the key_freq_set side.
interface key_freq_set_if;
  logic        key_up;
  logic        key_down;
  logic        key_step;
  logic [19:0] freq;
  logic [2:0]  step_idx;
  logic        freq_upd;

  modport master (
    output key_up, key_down, key_step,
    input  freq, step_idx, freq_upd
  );

  modport slave (
    input  key_up, key_down, key_step,
    output freq, step_idx, freq_upd
  );
endinterface

// File: rtl/key_freq_set.sv
// Debounced up/down/step keys adjust a saturated 20-bit frequency word for the DDS core.
// Define KEY_AUTO_REPEAT_EN to compile in hold-to-repeat on the up/down keys.
module key_freq_set #(
  parameter int DEB_CNT   = 1_000_000,
  parameter int RPT_DLY   = 25_000_000,
  parameter int RPT_PER   = 5_000_000,
  parameter int FREQ_MIN  = 1,
  parameter int FREQ_MAX  = 1_000_000,
  parameter int FREQ_INIT = 1_000
) (
  input logic           clk,
  input logic           rst_n,
  key_freq_set_if.slave bus
);

  localparam int CW   = $clog2(DEB_CNT);
  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_ST = 2;

  if (DEB_CNT < 2) begin : g_bad_deb
    $error("DEB_CNT must be at least 2");
  end
  if (RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_rpt
    $error("RPT_DLY and RPT_PER must be at least 1");
  end

  logic [2:0]    key_raw, s1, s2, deb, deb_d, press;
  logic [CW-1:0] cnt [3];

  assign key_raw = {bus.key_step, bus.key_down, bus.key_up};

  // Idle level of every key stage is 1 (released), so a held key must re-debounce after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      deb_d <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking so s1 -> s2 -> deb behave as a true register chain.
      s1    <= key_raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CNT - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_d & ~deb;

  logic rpt_up, rpt_dn;

`ifdef KEY_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

  rpt_state_e  state, state_nx;
  logic [31:0] timer, timer_nx;
  logic        dir_up, dir_up_nx, rpt_fire;
  logic        held_rel, both_low;

  assign held_rel = dir_up ? deb[K_UP] : deb[K_DN];
  assign both_low = ~deb[K_UP] & ~deb[K_DN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      dir_up <= 1'b0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      dir_up <= dir_up_nx;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nx  = state;
    timer_nx  = timer + 32'd1;
    dir_up_nx = dir_up;
    rpt_fire  = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if ((press[K_UP] | press[K_DN]) && (deb[K_UP] ^ deb[K_DN])) begin
          state_nx  = HOLD;
          dir_up_nx = ~deb[K_UP];
        end
      end
      HOLD, REPEAT: begin
        // Release of the held key, or both keys down, always wins over a pending repeat.
        if (held_rel || both_low) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer == ((state == HOLD) ? 32'(RPT_DLY - 1) : 32'(RPT_PER - 1))) begin
          rpt_fire = 1'b1;
          timer_nx = '0;
          state_nx = REPEAT;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  assign rpt_up = rpt_fire & dir_up;
  assign rpt_dn = rpt_fire & ~dir_up;
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  logic [19:0]        freq, freq_nx, step_val;
  logic [2:0]         step_idx;
  logic               freq_upd, inc, dec;
  logic [20:0]        up_sum;
  logic signed [20:0] dn_diff;

  always_comb begin
    case (step_idx)
      3'd1:    step_val = 20'd10;
      3'd2:    step_val = 20'd100;
      3'd3:    step_val = 20'd1_000;
      3'd4:    step_val = 20'd10_000;
      default: step_val = 20'd1;
    endcase
  end

  assign inc = press[K_UP] | rpt_up;
  assign dec = press[K_DN] | rpt_dn;

  // One extra bit keeps the sum from wrapping and lets the difference go negative before clamping.
  always_comb begin
    up_sum  = {1'b0, freq} + {1'b0, step_val};
    dn_diff = $signed({1'b0, freq}) - $signed({1'b0, step_val});
    freq_nx = freq;
    if (inc && !dec) begin
      freq_nx = (up_sum > 21'(FREQ_MAX)) ? 20'(FREQ_MAX) : up_sum[19:0];
    end else if (dec && !inc) begin
      freq_nx = (dn_diff < $signed(21'(FREQ_MIN))) ? 20'(FREQ_MIN) : dn_diff[19:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq     <= 20'(FREQ_INIT);
      freq_upd <= 1'b0;
      step_idx <= '0;
    end else begin
      freq     <= freq_nx;
      freq_upd <= (freq_nx != freq);
      if (press[K_ST]) step_idx <= (step_idx == 3'd4) ? 3'd0 : step_idx + 3'd1;
    end
  end

  assign bus.freq     = freq;
  assign bus.step_idx = step_idx;
  assign bus.freq_upd = freq_upd;

endmodule

// File: doc/key_freq_set.md
# key_freq_set

Front-panel frequency-entry stage that drives the 20-bit `freq` input of the DDS top level. It synchronizes and debounces three active-low push-buttons (up, down, step-size) and maintains a registered frequency word. The word is saturated to a configurable range. An optional auto-repeat steps the frequency continuously while a key is held. Output feeds the frequency-control stage directly and needs no further conditioning.

## Interface
- `DEB_CNT`, 1_000_000: stable cycles required to accept a key level (20 ms at 50 MHz); must be ≥2.
- `RPT_DLY`, 25_000_000: held cycles after the accepted press before the first auto-repeat step.
- `RPT_PER`, 5_000_000: cycles between subsequent auto-repeat steps.
- `FREQ_MIN`, 1: lower saturation bound.
- `FREQ_MAX`, 1_000_000: upper saturation bound, ≤ 2^20−1.
- `FREQ_INIT`, 1_000: reset value of `freq`; FREQ_MIN ≤ FREQ_INIT ≤ FREQ_MAX.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_up` in 1: raw button, active-low, asynchronous to `clk`.
- `key_down` in 1: raw button, active-low, asynchronous to `clk`.
- `key_step` in 1: raw button, active-low; cycles the step size.
- `freq` out 20: current frequency word; reset = FREQ_INIT.
- `step_idx` out 3: current step index 0..4; reset = 0.
- `freq_upd` out 1: one-cycle pulse, high in the cycle `freq` takes a new, different value; reset = 0.

## Operation
- Each key passes through a 2-flop synchronizer (s1, s2), which resets to 1.
- Each key then has a debouncer: level `deb` (reset 1) and counter `cnt` (reset 0).
  - If s2 == deb: cnt ← 0.
  - Otherwise cnt increments; when cnt == DEB_CNT−1, deb ← s2 and cnt ← 0.
  - A single-cycle glitch only restarts the count.
- A press event is the debounced 1→0 transition. Release produces no event.
- Step table: idx 0..4 → 1, 10, 100, 1_000, 10_000.
  - A step press sets idx ← idx+1; after 4 it wraps to 0.
  - The new step size applies from the next event onward.
- Up event: freq ← min(freq+step, FREQ_MAX). Down event: freq ← max(freq−step, FREQ_MIN).
  - Sum and difference are computed 21-bit and signed, so no wrap-around occurs before the clamp.
- Up and down events in the same cycle: no change and no `freq_upd`. A step event in that same cycle is still applied.
- An up/down event at a bound leaves `freq` unchanged and raises no `freq_upd`.
- Auto-repeat FSM, with states IDLE, HOLD, REPEAT and a 32-bit timer:
  - IDLE → HOLD on an up or down press event while exactly one of the deb_up/deb_down levels is 0. The timer clears.
  - HOLD: when timer == RPT_DLY−1, emit a repeat step in the held direction, clear the timer, and go to REPEAT.
  - REPEAT: every RPT_PER cycles, emit a repeat step.
  - Any state → IDLE when the held key's deb goes to 1, or when both deb_up and deb_down are 0.
  - The step key never repeats.
  - Repeat steps use the same saturation and `freq_upd` rules as press events.
- Reset asserted mid-operation: all registers return to their reset values immediately. After release, a key that is still held must re-debounce before it generates an event.

## Timing
- Count clock edges from the first edge that samples a new stable raw level as edge 1.
  - s1 changes at edge 1 and s2 at edge 2.
  - deb changes at edge 2+DEB_CNT.
  - `freq`, `step_idx` and `freq_upd` change at edge 3+DEB_CNT.
- Auto-repeat:
  - The first repeat updates `freq` RPT_DLY cycles after the press-event update.
  - Each later repeat follows RPT_PER cycles after the previous one.
- All outputs are registered. No combinational path runs from the inputs to the outputs.

## Configuration
- `KEY_AUTO_REPEAT_EN`:
  - Defined: auto-repeat FSM and timer are compiled in, as described above.
  - Undefined: FSM and timer are removed; only press events change `freq`; RPT_DLY and RPT_PER are ignored.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DEB_CNT=4, RPT_DLY=20, RPT_PER=5, FREQ_MIN=1, FREQ_MAX=1000, FREQ_INIT=100.
- Reset check: release reset → freq=100, step_idx=0, freq_upd=0. Single 10-cycle press of key_up → freq=101 exactly at edge 7, with a one-cycle `freq_upd`.
- Glitch rejection: key_down low for 3 cycles, then high → no change. Press step 5 times → step_idx 1, 2, 3, 4, 0.
- Saturation: step_idx=3, then freq 100 → up → 1000; up again → 1000 with no `freq_upd`. Down ×2 at idx 3 → 1, not a wrap.
- Simultaneous press: key_up and key_down fall in the same cycle → freq unchanged, no `freq_upd`, FSM stays IDLE.
- Auto-repeat (macro defined): hold key_up for 60 cycles at idx 0 from 100 → updates to 101 at the press, then 102 at +20 cycles, then 103, 104, … every 5 cycles. Release stops further updates. Macro undefined: only 101.
- Reset mid-operation: assert reset during REPEAT → freq=100 immediately. Key still held after release → one step to 101 after DEB_CNT+3 cycles.
